// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared bus width, arbiter state encoding and full byte-select constant.
package mem_bus_arbiter_pkg;
    localparam int REG_BUS_W = 32;
    localparam logic [3:0] SEL_ALL = 4'b1111;
    typedef enum logic [1:0] {ARB_IDLE, ARB_DATA, ARB_INST, ARB_DONE} arb_state_t;
endpackage

// File: rtl/arb_wait_timer.sv
// arb_wait_timer: counts bus wait cycles and flags when the configured timeout is reached.
module arb_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + CW'(1);
    end
    // A zero TIMEOUT never expires, so the arbiter waits indefinitely for ack.
    assign o_expired = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch and data ports, data first,
// stalling the pipeline until all pending accesses finish, with an ack timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int          ADDR_W  = REG_BUS_W,
    parameter int          DATA_W  = REG_BUS_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [ADDR_W-1:0] rom_addr_i,
    output logic [DATA_W-1:0] rom_data_o,
    input  logic              ram_ce_i,
    input  logic              ram_we_i,
    input  logic [3:0]        ram_sel_i,
    input  logic [ADDR_W-1:0] ram_addr_i,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              stallreq_o,
    output logic              bus_err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i
);
    arb_state_t r_state, w_next;
    logic w_ack, w_exp, w_tmo, w_fin;
    // Acks are only meaningful while a request is on the bus; ack beats timeout.
    assign w_ack = bus_req_o && bus_ack_i;
    assign w_tmo = bus_req_o && w_exp && !bus_ack_i;
    assign w_fin = w_ack || w_tmo;
    arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_next != r_state),
        .i_en     (bus_req_o && !bus_ack_i),
        .o_expired(w_exp)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE: w_next = ram_ce_i ? ARB_DATA : rom_ce_i ? ARB_INST : ARB_IDLE;
            ARB_DATA: w_next = !w_fin ? ARB_DATA : rom_ce_i ? ARB_INST : ARB_DONE;
            ARB_INST: w_next = w_fin ? ARB_DONE : ARB_INST;
            default:  w_next = ARB_IDLE;
        endcase
    end
    assign stallreq_o = !rst && ((r_state == ARB_IDLE) ? (rom_ce_i || ram_ce_i) : (r_state != ARB_DONE));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_err_o   <= 1'b0;
            rom_data_o  <= '0;
            ram_data_o  <= '0;
        end else begin
            r_state   <= w_next;
            bus_err_o <= w_tmo;
            if (r_state == ARB_DATA && w_fin) ram_data_o <= (w_ack && !bus_we_o) ? bus_rdata_i : '0;
            if (r_state == ARB_INST && w_fin) rom_data_o <= w_ack ? bus_rdata_i : '0;
            if (r_state == ARB_IDLE && w_next == ARB_DATA) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= ram_we_i;
                bus_sel_o   <= ram_sel_i;
                bus_addr_o  <= ram_addr_i;
                bus_wdata_o <= ram_data_i;
            end else if (r_state != ARB_INST && w_next == ARB_INST) begin
                // Back-to-back data then fetch keeps the request asserted.
                bus_req_o  <= 1'b1;
                bus_we_o   <= 1'b0;
                bus_sel_o  <= SEL_ALL;
                bus_addr_o <= rom_addr_i;
            end else if (w_next == ARB_DONE) begin
                bus_req_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized and directed checks of the bus arbiter against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int T = 4;
    logic        clk = 0, rst = 1;
    logic        rom_ce = 0, ram_ce = 0, ram_we = 0, ack = 0;
    logic [3:0]  ram_sel = 0;
    logic [31:0] rom_addr = 0, ram_addr = 0, ram_wdata = 0, rdata = 0;
    logic [31:0] rom_data, ram_data, bus_addr, bus_wdata;
    logic        stallreq, bus_err, bus_req, bus_we;
    logic [3:0]  bus_sel;
    int          n_chk = 0, n_pass = 0;
    logic [31:0] exp_rom = 0, exp_ram = 0;
    bit          pend_err = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data),
        .ram_ce_i(ram_ce), .ram_we_i(ram_we), .ram_sel_i(ram_sel), .ram_addr_i(ram_addr),
        .ram_data_i(ram_wdata), .ram_data_o(ram_data),
        .stallreq_o(stallreq), .bus_err_o(bus_err),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_sel_o(bus_sel), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_rdata_i(rdata), .bus_ack_i(ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One access window: optional data access then optional fetch, each acked after
    // 'wait' idle cycles (wait > T means no ack ever arrives, forcing a timeout).
    task automatic run_txn(input bit dce, input bit we, input logic [3:0] sel, input logic [31:0] da,
                           input logic [31:0] wd, input logic [31:0] drd, input int dwait,
                           input bit ice, input logic [31:0] ia, input logic [31:0] ird,
                           input int iwait, input bit stray);
        @(negedge clk);
        ram_ce = dce; ram_we = we; ram_sel = sel; ram_addr = da; ram_wdata = wd;
        rom_ce = ice; rom_addr = ia; ack = stray; rdata = $urandom;
        #1;
        n_chk++;
        if ({stallreq, bus_req, bus_err} !== 3'b100)
            $display("FAIL idle_req: stall/req/err=%b expected 100", {stallreq, bus_req, bus_err});
        else n_pass++;
        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            if ((p == 0 && dce) || (p == 1 && ice)) begin
                int          w, n;
                logic [31:0] ea;
                logic [3:0]  es;
                bit          ew;
                w  = p ? iwait : dwait;
                n  = (w > T) ? T + 1 : w + 1;
                ea = p ? ia : da;
                es = p ? 4'hf : sel;
                ew = p ? 1'b0 : we;
                for (int k = 0; k < n; k++) begin
                    @(negedge clk);
                    rdata = p ? ird : drd;
                    ack = (k == w);
                    #1;
                    n_chk++;
                    if ({stallreq, bus_req, bus_we, bus_sel, bus_addr} !== {1'b1, 1'b1, ew, es, ea})
                        $display("FAIL bus_phase%0d_cyc%0d: stall,req,we,sel,addr=%b,%b,%b,%h,%h expected 1,1,%b,%h,%h",
                                 p, k, stallreq, bus_req, bus_we, bus_sel, bus_addr, ew, es, ea);
                    else n_pass++;
                    n_chk++;
                    if (bus_err !== pend_err) $display("FAIL err_phase%0d_cyc%0d: got %b expected %b", p, k, bus_err, pend_err);
                    else n_pass++;
                    if (p == 0) begin
                        n_chk++;
                        if (bus_wdata !== wd) $display("FAIL wdata_cyc%0d: got %h expected %h", k, bus_wdata, wd);
                        else n_pass++;
                    end
                    pend_err = (w > T) && (k == T);
                    @(posedge clk);
                end
                if (p == 0) exp_ram = (w > T || we) ? 32'h0 : drd;
                else exp_rom = (w > T) ? 32'h0 : ird;
            end
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({stallreq, bus_req, bus_err} !== {2'b00, pend_err})
            $display("FAIL done_ctl: stall/req/err=%b expected 00%b", {stallreq, bus_req, bus_err}, pend_err);
        else n_pass++;
        n_chk++;
        if ({ram_data, rom_data} !== {exp_ram, exp_rom})
            $display("FAIL done_data: ram/rom=%h/%h expected %h/%h", ram_data, rom_data, exp_ram, exp_rom);
        else n_pass++;
        pend_err = 0;
        ram_ce = 0; rom_ce = 0; ack = 0;
        @(posedge clk);
    endtask

    task automatic test_reset;
        rom_ce = 1; ram_ce = 1; ack = 1;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if ({stallreq, bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err, rom_data, ram_data} !== '0)
            $display("FAIL reset_outputs: stall=%b req=%b addr=%h rom=%h ram=%h expected all zero",
                     stallreq, bus_req, bus_addr, rom_data, ram_data);
        else n_pass++;
        rom_ce = 0; ram_ce = 0; ack = 0; rst = 0;
        @(posedge clk);
    endtask

    task automatic test_fetch_only;
        run_txn(0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 32'h00000013, 0, 1);
    endtask

    task automatic test_load_fetch;
        run_txn(1, 0, 4'hf, 32'h2000, 32'h0, 32'hDEADBEEF, 0, 1, 32'h104, 32'h00410093, 0, 0);
    endtask

    task automatic test_store_waits;
        run_txn(1, 1, 4'b0011, 32'h3000, 32'h0000ABCD, 32'h5555AAAA, 2, 1, 32'h108, 32'h12345678, 0, 0);
    endtask

    task automatic test_timeout;
        run_txn(1, 0, 4'hf, 32'h4000, 32'h0, 32'hCAFEF00D, T + 3, 1, 32'h10C, 32'h0BADC0DE, 1, 0);
        run_txn(0, 0, 0, 0, 0, 0, 0, 1, 32'h110, 32'hFFFF0000, T + 1, 0);
    endtask

    task automatic test_collision;
        run_txn(1, 0, 4'hf, 32'h5000, 32'h0, 32'h600DF00D, T, 0, 0, 0, 0, 0);
    endtask

    task automatic test_stray_ack;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ack = 1; rdata = $urandom;
            #1;
            n_chk++;
            if ({stallreq, bus_req, bus_err, ram_data, rom_data} !== {3'b000, exp_ram, exp_rom})
                $display("FAIL stray_ack_%0d: stall/req/err=%b ram=%h rom=%h expected 000 %h %h",
                         k, {stallreq, bus_req, bus_err}, ram_data, rom_data, exp_ram, exp_rom);
            else n_pass++;
        end
        ack = 0;
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            bit dce, ice;
            dce = 1'($urandom);
            ice = dce ? 1'($urandom) : 1'b1;
            run_txn(dce, 1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, T + 2),
                    ice, $urandom, $urandom, $urandom_range(0, T + 2), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        rom_ce = 1; rom_addr = 32'h200; ack = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        n_chk++;
        if ({stallreq, bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err, rom_data, ram_data} !== '0)
            $display("FAIL reset_mid: stall=%b req=%b addr=%h rom=%h ram=%h expected all zero",
                     stallreq, bus_req, bus_addr, rom_data, ram_data);
        else n_pass++;
        exp_rom = 0; exp_ram = 0; pend_err = 0;
        @(negedge clk);
        rst = 0; rom_ce = 0; ack = 1; rdata = 32'hFEEDFACE;
        repeat (2) begin
            @(negedge clk);
            #1;
            n_chk++;
            if ({stallreq, bus_req, bus_err, rom_data} !== {3'b000, 32'h0})
                $display("FAIL late_ack: stall/req/err=%b rom=%h expected 000 0", {stallreq, bus_req, bus_err}, rom_data);
            else n_pass++;
        end
        ack = 0;
        run_txn(0, 0, 0, 0, 0, 0, 0, 1, 32'h204, 32'h00000073, 1, 0);
    endtask

    initial begin
        test_reset;
        test_fetch_only;
        test_load_fetch;
        test_store_waits;
        test_timeout;
        test_collision;
        test_stray_ack;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
